nand23_stim_gen: RTL and testbench



---
 rtl/nand23_stim_gen.sv | 155 +++++++++++++++
 tb/tb_nand23_stim_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nand23_stim_gen.sv
// Deterministic operand-pair generator for the 23-bit NAND datapath: two LFSRs behind a valid/ready handshake.
// Optional result checker is included when NAND23_STIM_GEN_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, no pair offered
// RUN   | offering pairs, stepping LFSRs on each accept
// DONE  | COUNT pairs accepted, waiting for a restart
module nand23_stim_gen #(
  parameter int          COUNT  = 10000,
  parameter logic [22:0] SEED_A = 23'h000001,
  parameter logic [22:0] SEED_B = 23'h5A5A5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ready_i,
`ifdef NAND23_STIM_GEN_CHECK_EN
  input  logic [22:0] c_i,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
`endif
  output logic [22:0] a_o,
  output logic [22:0] b_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [19:0] count_o
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [22:0] SEED_A_C = (SEED_A == 23'h0) ? 23'h000001 : SEED_A;
  localparam logic [22:0] SEED_B_C = (SEED_B == 23'h0) ? 23'h000001 : SEED_B;
  localparam logic [19:0] COUNT_C  = 20'(COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [22:0] lfsr_next(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[17]};
  endfunction

  state_t      state_q, state_d;
  logic [22:0] a_q, a_d, b_q, b_d;
  logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [19:0] count_q, count_d;
  logic        accept, start_acc;

  assign accept    = valid_q && ready_i;
  assign start_acc = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d = 20'd0;
          if (COUNT_C != 20'd0) begin
            a_d     = SEED_A_C;
            b_d     = SEED_B_C;
            valid_d = 1'b1;
            state_d = RUN;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          count_d = count_q + 20'd1;
          a_d     = lfsr_next(a_q);
          b_d     = lfsr_next(b_q);
          if (count_q + 20'd1 == COUNT_C) begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

`ifdef NAND23_STIM_GEN_CHECK_EN
  logic [22:0] exp_q, exp_d;
  logic        pend_q, pend_d, err_q, err_d, mism;
  logic [15:0] err_cnt_q, err_cnt_d;

  // c_i is judged the cycle after the pair it answers was accepted.
  always_comb begin
    exp_d     = accept ? ~(a_q & b_q) : exp_q;
    pend_d    = accept;
    mism      = pend_q && (c_i != exp_q);
    err_d     = mism;
    err_cnt_d = err_cnt_q;
    if (start_acc)
      err_cnt_d = 16'd0;
    else if (mism && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 23'h0;
      b_q       <= 23'h0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 20'd0;
`ifdef NAND23_STIM_GEN_CHECK_EN
      exp_q     <= 23'h0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
`ifdef NAND23_STIM_GEN_CHECK_EN
      exp_q     <= exp_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_nand23_stim_gen.sv
// Directed-vector bench for nand23_stim_gen: main generator, COUNT=0 and zero-seed variants,
// plus the result checker when NAND23_STIM_GEN_CHECK_EN is defined.
module tb_nand23_stim_gen;

  logic clk = 1'b0;
  logic rst, ready, s0, s1, s2;
  always #5 clk = ~clk;

  logic [22:0] a0, b0, a1, b1, a2, b2;
  logic        v0, bz0, d0, v1, bz1, d1, v2, bz2, d2;
  logic [19:0] c0, c1, c2;

  int checks   = 0;
  int failures = 0;

`ifdef NAND23_STIM_GEN_CHECK_EN
  logic [22:0] cin0, cin1, cin2;
  logic        e0, e1, e2;
  logic [15:0] ec0, ec1, ec2;
  assign cin0 = 23'h0;
  assign cin1 = 23'h0;
  assign cin2 = 23'h0;
`endif

  nand23_stim_gen #(.COUNT(6), .SEED_A(23'h000001), .SEED_B(23'h5A5A5A)) u0 (
    .clk(clk), .rst(rst), .start(s0), .ready_i(ready),
`ifdef NAND23_STIM_GEN_CHECK_EN
    .c_i(cin0), .err_o(e0), .err_cnt_o(ec0),
`endif
    .a_o(a0), .b_o(b0), .valid_o(v0), .busy_o(bz0), .done_o(d0), .count_o(c0));

  nand23_stim_gen #(.COUNT(0)) u1 (
    .clk(clk), .rst(rst), .start(s1), .ready_i(ready),
`ifdef NAND23_STIM_GEN_CHECK_EN
    .c_i(cin1), .err_o(e1), .err_cnt_o(ec1),
`endif
    .a_o(a1), .b_o(b1), .valid_o(v1), .busy_o(bz1), .done_o(d1), .count_o(c1));

  nand23_stim_gen #(.COUNT(2), .SEED_A(23'h0), .SEED_B(23'h0)) u2 (
    .clk(clk), .rst(rst), .start(s2), .ready_i(ready),
`ifdef NAND23_STIM_GEN_CHECK_EN
    .c_i(cin2), .err_o(e2), .err_cnt_o(ec2),
`endif
    .a_o(a2), .b_o(b2), .valid_o(v2), .busy_o(bz2), .done_o(d2), .count_o(c2));

`ifdef NAND23_STIM_GEN_CHECK_EN
  logic        s3, r3, inject;
  logic [22:0] a3, b3, cin3;
  logic        v3, bz3, d3, e3;
  logic [19:0] c3;
  logic [15:0] ec3;
  int          pulses = 0;

  nand23_stim_gen #(.COUNT(10000)) u3 (
    .clk(clk), .rst(rst), .start(s3), .ready_i(r3),
    .c_i(cin3), .err_o(e3), .err_cnt_o(ec3),
    .a_o(a3), .b_o(b3), .valid_o(v3), .busy_o(bz3), .done_o(d3), .count_o(c3));

  // Reference NAND answering each accepted pair one cycle later; bit 0 flipped on beat 7 when injecting.
  always @(posedge clk)
    if (v3 && r3)
      cin3 <= ~(a3 & b3) ^ ((inject && c3 == 20'd7) ? 23'h1 : 23'h0);

  always @(posedge clk) if (e3) pulses <= pulses + 1;
`endif

  typedef struct {
    logic        st;
    logic        rdy;
    logic [22:0] a;
    logic [22:0] b;
    logic        v;
    logic        bz;
    logic        dn;
    logic [19:0] cnt;
  } vec_t;

  vec_t vt[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] pk(input logic [22:0] a, input logic [22:0] b, input logic v,
                                     input logic bz, input logic dn, input logic [19:0] cnt);
    return {a, b, v, bz, dn, cnt};
  endfunction

  initial begin
    // start, ready -> a, b, valid, busy, done, count (COUNT=6 instance)
    vt[0]  = '{1'b0, 1'b0, 23'h000000, 23'h000000, 1'b0, 1'b0, 1'b0, 20'd0};
    vt[1]  = '{1'b1, 1'b1, 23'h000001, 23'h5A5A5A, 1'b1, 1'b1, 1'b0, 20'd0};
    vt[2]  = '{1'b0, 1'b1, 23'h000002, 23'h34B4B4, 1'b1, 1'b1, 1'b0, 20'd1};
    vt[3]  = '{1'b0, 1'b0, 23'h000002, 23'h34B4B4, 1'b1, 1'b1, 1'b0, 20'd1};
    vt[4]  = '{1'b0, 1'b0, 23'h000002, 23'h34B4B4, 1'b1, 1'b1, 1'b0, 20'd1};
    vt[5]  = '{1'b0, 1'b1, 23'h000004, 23'h696968, 1'b1, 1'b1, 1'b0, 20'd2};
    vt[6]  = '{1'b1, 1'b1, 23'h000008, 23'h52D2D1, 1'b1, 1'b1, 1'b0, 20'd3};
    vt[7]  = '{1'b0, 1'b1, 23'h000010, 23'h25A5A2, 1'b1, 1'b1, 1'b0, 20'd4};
    vt[8]  = '{1'b0, 1'b1, 23'h000020, 23'h4B4B44, 1'b1, 1'b1, 1'b0, 20'd5};
    vt[9]  = '{1'b0, 1'b1, 23'h000040, 23'h169688, 1'b0, 1'b0, 1'b1, 20'd6};
    vt[10] = '{1'b0, 1'b1, 23'h000040, 23'h169688, 1'b0, 1'b0, 1'b1, 20'd6};
    vt[11] = '{1'b1, 1'b1, 23'h000001, 23'h5A5A5A, 1'b1, 1'b1, 1'b0, 20'd0};

    rst = 1'b1; ready = 1'b0; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
`ifdef NAND23_STIM_GEN_CHECK_EN
    s3 = 1'b0; r3 = 1'b1; inject = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_u0", pk(a0, b0, v0, bz0, d0, c0), 69'h0);
    end
    chk("idle_u1", pk(a1, b1, v1, bz1, d1, c1), 69'h0);
    chk("idle_u2", pk(a2, b2, v2, bz2, d2, c2), 69'h0);

    for (int i = 0; i < 12; i++) begin
      s0 = vt[i].st; ready = vt[i].rdy;
      tick;
      chk($sformatf("vec%0d", i), pk(a0, b0, v0, bz0, d0, c0),
          pk(vt[i].a, vt[i].b, vt[i].v, vt[i].bz, vt[i].dn, vt[i].cnt));
    end

    // restarted run: two accepts, five stalled cycles, then resume
    s0 = 1'b0; ready = 1'b1;
    tick; tick;
    chk("pre_stall", pk(a0, b0, v0, bz0, d0, c0), pk(23'h4, 23'h696968, 1, 1, 0, 20'd2));
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall", pk(a0, b0, v0, bz0, d0, c0), pk(23'h4, 23'h696968, 1, 1, 0, 20'd2));
    end
    ready = 1'b1;
    tick;
    chk("resume", pk(a0, b0, v0, bz0, d0, c0), pk(23'h8, 23'h52D2D1, 1, 1, 0, 20'd3));

    // reset at count 3 aborts the run
    rst = 1'b1;
    tick;
    chk("mid_rst", pk(a0, b0, v0, bz0, d0, c0), 69'h0);
    rst = 1'b0; s0 = 1'b1;
    tick;
    chk("post_rst_start", pk(a0, b0, v0, bz0, d0, c0), pk(23'h1, 23'h5A5A5A, 1, 1, 0, 20'd0));
    s0 = 1'b0;

    // COUNT=0: straight to DONE, never valid
    s1 = 1'b1;
    tick;
    chk("cnt0_start", pk(a1, b1, v1, bz1, d1, c1), pk(23'h0, 23'h0, 0, 0, 1, 20'd0));
    s1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("cnt0_hold", pk(a1, b1, v1, bz1, d1, c1), pk(23'h0, 23'h0, 0, 0, 1, 20'd0));
    end
    s1 = 1'b1;
    tick;
    chk("cnt0_restart", pk(a1, b1, v1, bz1, d1, c1), pk(23'h0, 23'h0, 0, 0, 1, 20'd0));
    s1 = 1'b0;

    // zero seeds replaced by 1
    s2 = 1'b1;
    tick;
    s2 = 1'b0;
    chk("zseed_load", pk(a2, b2, v2, bz2, d2, c2), pk(23'h1, 23'h1, 1, 1, 0, 20'd0));
    tick;
    chk("zseed_step", pk(a2, b2, v2, bz2, d2, c2), pk(23'h2, 23'h2, 1, 1, 0, 20'd1));
    tick;
    chk("zseed_done", pk(a2, b2, v2, bz2, d2, c2), pk(23'h4, 23'h4, 0, 0, 1, 20'd2));

`ifdef NAND23_STIM_GEN_CHECK_EN
    for (int run = 0; run < 2; run++) begin
      int budget;
      inject = (run == 1);
      pulses = 0;
      s3 = 1'b1;
      tick;
      s3 = 1'b0;
      if (run == 1) chk("errcnt_clear", 69'(ec3), 69'd0);
      budget = 0;
      while (!d3 && budget < 20100) begin
        tick;
        budget++;
      end
      chk("chk_done", 69'(d3), 69'd1);
      tick; tick; tick;
      chk($sformatf("errcnt_run%0d", run), 69'(ec3), 69'(run));
      chk($sformatf("pulses_run%0d", run), 69'(pulses), 69'(run));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
